branch_resolve_unit: RTL and testbench

//   Resolves conditional branches (BNE/BEQ/BGZ/BLZ) in EX against the fetch-stage prediction.

---
 rtl/branch_resolve_unit_if.sv | 57 +++++
 rtl/branch_resolve_unit.sv | 182 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Handshake bundle between EX, fetch redirect and predictor update.
// slave = the resolve unit; master = the surrounding pipeline.
interface branch_resolve_unit_if;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_instr;
    logic [15:0] res_pc;
    logic [15:0] res_pred_pc;
    logic [15:0] res_rs;
    logic [15:0] res_rt;

    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        flush;

    logic        upd_valid;
    logic        upd_ready;
    logic [15:0] upd_pc;
    logic [15:0] upd_target;
    logic        upd_taken;

    modport slave (
        input  res_valid,
        output res_ready,
        input  res_instr,
        input  res_pc,
        input  res_pred_pc,
        input  res_rs,
        input  res_rt,
        output redirect_valid,
        output redirect_pc,
        output flush,
        output upd_valid,
        input  upd_ready,
        output upd_pc,
        output upd_target,
        output upd_taken
    );

    modport master (
        output res_valid,
        input  res_ready,
        output res_instr,
        output res_pc,
        output res_pred_pc,
        output res_rs,
        output res_rt,
        input  redirect_valid,
        input  redirect_pc,
        input  flush,
        input  upd_valid,
        output upd_ready,
        input  upd_pc,
        input  upd_target,
        input  upd_taken
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolve: redirect/flush on mispredict, predictor update FIFO.
// Optional stats counters built when BRANCH_RESOLVE_STATS_EN is defined.
module branch_resolve_unit #(
    parameter int UPD_DEPTH     = 4,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    branch_resolve_unit_if.slave  bus,
    output logic [15:0]           stat_branches,
    output logic [15:0]           stat_mispred
);

    localparam int PW = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(SQUASH_CYCLES + 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] SQUASH = 1'b1;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] target;
        logic        taken;
    } upd_entry_t;

    logic [3:0]  opcode;
    logic [15:0] imm_sext;
    logic        op_bne;
    logic        op_beq;
    logic        op_bgz;
    logic        op_blz;
    logic        is_branch;
    logic        taken;
    logic [15:0] target;
    logic [15:0] fallthru;
    logic [15:0] actual;
    logic        mispredict;
    logic        accept;
    logic        pop;
    logic        full;
    logic        unused_bits;

    logic [0:0]    state;
    logic [SW-1:0] squash_cnt;

    upd_entry_t    mem [UPD_DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;

    logic          redir_q;
    logic [15:0]   redir_pc_q;

    assign opcode    = bus.res_instr[15:12];
    assign imm_sext  = {{8{bus.res_instr[7]}}, bus.res_instr[7:0]};
    assign op_bne    = (opcode == 4'd0);
    assign op_beq    = (opcode == 4'd1);
    assign op_bgz    = (opcode == 4'd2);
    assign op_blz    = (opcode == 4'd3);
    assign is_branch = op_bne | op_beq | op_bgz | op_blz;

    assign unused_bits = ^bus.res_instr[11:8];

    // Branch condition evaluation from forwarded operands
    always_comb begin
        taken = 1'b0;
        unique case (1'b1)
            op_bne:  taken = (bus.res_rs != bus.res_rt);
            op_beq:  taken = (bus.res_rs == bus.res_rt);
            op_bgz:  taken = ($signed(bus.res_rs) > 16'sd0);
            op_blz:  taken = ($signed(bus.res_rs) < 16'sd0);
            default: taken = 1'b0;
        endcase
    end

    assign target     = bus.res_pc + 16'd1 + imm_sext;
    assign fallthru   = bus.res_pc + 16'd1;
    assign actual     = taken ? target : fallthru;
    assign mispredict = (actual != bus.res_pred_pc);

    assign full          = (count == CW'(UPD_DEPTH));
    assign bus.res_ready = ~full;

    assign accept = bus.res_valid & ~full & (state == IDLE) & is_branch;

    assign bus.upd_valid  = (count != '0);
    assign pop            = bus.upd_valid & bus.upd_ready;
    assign bus.upd_pc     = mem[rptr].pc;
    assign bus.upd_target = mem[rptr].target;
    assign bus.upd_taken  = mem[rptr].taken;

    // Update FIFO: storage, pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < UPD_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (accept) begin
                mem[wptr] <= '{pc: bus.res_pc, target: target, taken: taken};
                wptr      <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // One-cycle redirect pulse after a mispredicting accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
        end else begin
            redir_q    <= accept & mispredict;
            redir_pc_q <= (accept & mispredict) ? actual : 16'h0000;
        end
    end

    assign bus.redirect_valid = redir_q;
    assign bus.redirect_pc    = redir_pc_q;
    assign bus.flush          = redir_q;

    // Wrong-path squash window following a redirect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            squash_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && mispredict) begin
                        state      <= SQUASH;
                        squash_cnt <= SW'(SQUASH_CYCLES);
                    end
                end
                SQUASH: begin
                    if (squash_cnt <= SW'(1)) begin
                        state      <= IDLE;
                        squash_cnt <= '0;
                    end else begin
                        squash_cnt <= squash_cnt - SW'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    squash_cnt <= '0;
                end
            endcase
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    // Saturating resolved-branch and mispredict counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (accept && (stat_branches != 16'hFFFF)) begin
                stat_branches <= stat_branches + 16'd1;
            end
            if (accept && mispredict && (stat_mispred != 16'hFFFF)) begin
                stat_mispred <= stat_mispred + 16'd1;
            end
        end
    end
`else
    assign stat_branches = 16'h0000;
    assign stat_mispred  = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit.
// Directed vectors; monitor compares update and redirect streams.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] stat_branches;
    logic [15:0] stat_mispred;

    always #5 clk = ~clk;

    branch_resolve_unit_if bus ();

    branch_resolve_unit #(
        .UPD_DEPTH(4),
        .SQUASH_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave),
        .stat_branches(stat_branches),
        .stat_mispred(stat_mispred)
    );

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] target;
        logic        taken;
    } upd_t;

    upd_t        exp_upd[$];
    logic [15:0] exp_redir[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          mon_en   = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(logic v, logic [3:0] op, logic [7:0] imm,
                         logic [15:0] pc, logic [15:0] pred,
                         logic [15:0] rs, logic [15:0] rt);
        bus.res_valid   = v;
        bus.res_instr   = {op, 4'h0, imm};
        bus.res_pc      = pc;
        bus.res_pred_pc = pred;
        bus.res_rs      = rs;
        bus.res_rt      = rt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        bus.res_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_push(logic [15:0] pc, logic [15:0] tgt, logic tk);
        upd_t e;
        e.pc     = pc;
        e.target = tgt;
        e.taken  = tk;
        exp_upd.push_back(e);
    endtask

    // Monitor: compare head / redirect against the scoreboard queues
    always @(negedge clk) begin : monitor
        upd_t e;
        logic [15:0] r;
        if (mon_en && reset_n) begin
            if (bus.upd_valid) begin
                if (exp_upd.size() == 0) begin
                    n_checks++;
                    $display("FAIL upd_unexpected: got pc=%h tgt=%h expected none",
                             bus.upd_pc, bus.upd_target);
                end else begin
                    e = exp_upd[0];
                    check("upd_pc", {16'h0, bus.upd_pc}, {16'h0, e.pc});
                    check("upd_target", {16'h0, bus.upd_target}, {16'h0, e.target});
                    check("upd_taken", {31'h0, bus.upd_taken}, {31'h0, e.taken});
                    if (bus.upd_ready) void'(exp_upd.pop_front());
                end
            end
            if (bus.redirect_valid || bus.flush) begin
                check("flush_with_redirect", {31'h0, bus.flush}, {31'h0, bus.redirect_valid});
                if (exp_redir.size() == 0) begin
                    n_checks++;
                    $display("FAIL redirect_unexpected: got pc=%h expected none",
                             bus.redirect_pc);
                end else begin
                    r = exp_redir.pop_front();
                    check("redirect_pc", {16'h0, bus.redirect_pc}, {16'h0, r});
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset_n         = 1'b0;
        bus.res_valid   = 1'b0;
        bus.res_instr   = '0;
        bus.res_pc      = '0;
        bus.res_pred_pc = '0;
        bus.res_rs      = '0;
        bus.res_rt      = '0;
        bus.upd_ready   = 1'b0;
        #1;
        check("rst_res_ready", {31'h0, bus.res_ready}, 32'd1);
        check("rst_upd_valid", {31'h0, bus.upd_valid}, 32'd0);
        check("rst_redirect", {31'h0, bus.redirect_valid}, 32'd0);
        check("rst_flush", {31'h0, bus.flush}, 32'd0);
        check("rst_redirect_pc", {16'h0, bus.redirect_pc}, 32'd0);
        check("rst_stats", {stat_branches, stat_mispred}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n       = 1'b1;
        bus.upd_ready = 1'b1;
        mon_en        = 1'b1;

        // BEQ taken, predicted correctly
        exp_push(16'h0010, 16'h0016, 1'b1);
        check("pre_upd_valid", {31'h0, bus.upd_valid}, 32'd0);
        drive(1'b1, 4'h1, 8'h05, 16'h0010, 16'h0016, 16'd7, 16'd7);
        check("beq_upd_latency", {31'h0, bus.upd_valid}, 32'd1);
        check("beq_no_redirect", {31'h0, bus.redirect_valid}, 32'd0);
        idle(1);

        // BNE not taken, mispredicted; next two res_valid squashed
        exp_push(16'h0020, 16'h0030, 1'b0);
        exp_redir.push_back(16'h0021);
        drive(1'b1, 4'h0, 8'h0F, 16'h0020, 16'h0030, 16'd3, 16'd3);
        check("bne_redirect", {31'h0, bus.redirect_valid}, 32'd1);
        check("bne_flush", {31'h0, bus.flush}, 32'd1);
        drive(1'b1, 4'h1, 8'h02, 16'h0050, 16'h0099, 16'd1, 16'd1);
        check("redirect_one_cycle", {31'h0, bus.redirect_valid}, 32'd0);
        drive(1'b1, 4'h1, 8'h02, 16'h0051, 16'h0099, 16'd1, 16'd1);
        idle(2);

        // BLZ taken backward, mispredicted
        exp_push(16'h0040, 16'h003D, 1'b1);
        exp_redir.push_back(16'h003D);
        drive(1'b1, 4'h3, 8'hFC, 16'h0040, 16'h0041, 16'h8000, 16'd0);
        idle(3);

        // BGZ at top of memory, target wraps
        exp_push(16'hFFFF, 16'h0001, 1'b1);
        drive(1'b1, 4'h2, 8'h01, 16'hFFFF, 16'h0001, 16'd1, 16'd0);
        // Non-branch opcode: no side effect
        drive(1'b1, 4'h4, 8'h01, 16'h0080, 16'h0000, 16'd1, 16'd0);
        // BGZ with negative operand: not taken
        exp_push(16'h0100, 16'h0111, 1'b0);
        drive(1'b1, 4'h2, 8'h10, 16'h0100, 16'h0101, 16'h8000, 16'd0);
        idle(2);

        // Fill the FIFO with upd_ready low
        bus.upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] pc;
            pc = 16'h0200 + 16'(i * 16);
            exp_push(pc, pc + 16'd9, 1'b1);
            drive(1'b1, 4'h1, 8'h08, pc, pc + 16'd9, 16'd4, 16'd4);
        end
        check("full_not_ready", {31'h0, bus.res_ready}, 32'd0);
        exp_push(16'h0240, 16'h0243, 1'b1);
        drive(1'b1, 4'h0, 8'h02, 16'h0240, 16'h0243, 16'd1, 16'd2);
        check("fifth_held", {31'h0, bus.res_ready}, 32'd0);
        bus.upd_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_pop", {31'h0, bus.res_ready}, 32'd1);
        @(posedge clk);
        #1;
        idle(6);
        check("drained", {31'h0, bus.upd_valid}, 32'd0);

        // Async reset during SQUASH with two entries queued
        bus.upd_ready = 1'b0;
        exp_push(16'h0300, 16'h0302, 1'b1);
        drive(1'b1, 4'h1, 8'h01, 16'h0300, 16'h0302, 16'd5, 16'd5);
        exp_push(16'h0310, 16'h0312, 1'b1);
        exp_redir.push_back(16'h0312);
        drive(1'b1, 4'h1, 8'h01, 16'h0310, 16'h0311, 16'd5, 16'd5);
        bus.res_valid = 1'b0;
        reset_n = 1'b0;
        exp_upd.delete();
        exp_redir.delete();
        #1;
        check("midrst_upd_valid", {31'h0, bus.upd_valid}, 32'd0);
        check("midrst_redirect", {31'h0, bus.redirect_valid}, 32'd0);
        check("midrst_flush", {31'h0, bus.flush}, 32'd0);
        check("midrst_res_ready", {31'h0, bus.res_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        bus.upd_ready = 1'b1;

        // Three branches, one mispredict
        exp_push(16'h0400, 16'h0405, 1'b1);
        drive(1'b1, 4'h2, 8'h04, 16'h0400, 16'h0405, 16'd5, 16'd0);
        exp_push(16'h0410, 16'h0415, 1'b0);
        exp_redir.push_back(16'h0411);
        drive(1'b1, 4'h3, 8'h04, 16'h0410, 16'h0415, 16'd0, 16'd0);
        idle(3);
        exp_push(16'h0420, 16'h03A1, 1'b0);
        drive(1'b1, 4'h0, 8'h80, 16'h0420, 16'h0421, 16'd1, 16'd1);
        idle(3);
`ifdef BRANCH_RESOLVE_STATS_EN
        check("stat_branches", {16'h0, stat_branches}, 32'd3);
        check("stat_mispred", {16'h0, stat_mispred}, 32'd1);
`else
        check("stat_branches", {16'h0, stat_branches}, 32'd0);
        check("stat_mispred", {16'h0, stat_mispred}, 32'd0);
`endif

        check("upd_queue_empty", exp_upd.size(), 32'd0);
        check("redir_queue_empty", exp_redir.size(), 32'd0);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
